// File: rtl/sniffer_pkg.sv
// Shared definitions for the sniffer datapath.
//   frame_state_t : frame tracking FSM states
//   OFFSET_W      : width of reported frame byte offsets
//   BYTE_COUNT_W  : width of the saturating in-frame byte counter
//   clog2()       : ceiling log2 for index widths
package sniffer_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

    localparam int OFFSET_W     = 16;
    localparam int BYTE_COUNT_W = 17;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pattern_entry_cmp.sv
// Compares one pattern table entry against every byte alignment of the
// current scan window.
//   i_window     : history bytes followed by the new word (MSB = earliest)
//   i_pattern    : entry value, MSB byte matched first
//   i_enable     : entry enable
//   i_byte_count : in-frame bytes preceding the new word
//   o_hit[k]     : entry matches with its last byte at word byte k (0 = MSB)
module pattern_entry_cmp
    import sniffer_pkg::*;
#(
    parameter int PATTERN_BYTES = 6,
    parameter int DATA_BYTES    = 4
) (
    input  logic [8*(PATTERN_BYTES-1+DATA_BYTES)-1:0] i_window,
    input  logic [8*PATTERN_BYTES-1:0]                i_pattern,
    input  logic                                      i_enable,
    input  logic [BYTE_COUNT_W-1:0]                   i_byte_count,
    output logic [DATA_BYTES-1:0]                     o_hit
);

    localparam int WIN_BYTES = PATTERN_BYTES - 1 + DATA_BYTES;

    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_align
            logic [BYTE_COUNT_W:0] w_end_cnt;
            logic                  w_eq;
            logic                  w_in_frame;

            // Bytes seen in the frame up to and including word byte gi.
            assign w_end_cnt  = {1'b0, i_byte_count} + (BYTE_COUNT_W+1)'(gi + 1);
            // Window slice starting at window byte gi covers history tail plus
            // word bytes 0..gi.
            assign w_eq       = (i_window[8*(WIN_BYTES-gi)-1 -: 8*PATTERN_BYTES] == i_pattern);
            // Reject alignments that would reach back before the start of frame.
            assign w_in_frame = (w_end_cnt >= (BYTE_COUNT_W+1)'(PATTERN_BYTES));
            assign o_hit[gi]  = i_enable & w_eq & w_in_frame;
        end
    endgenerate

endmodule

// File: rtl/stream_pattern_matcher.sv
// Multi-pattern matcher for a framed byte stream carried in DATA_BYTES words.
//   clk, rst             : clock, synchronous active-high reset
//   clear                : flush frame state, history and delay line (table kept)
//   cfg_we/idx/pattern/enable : pattern table write port
//   data_valid/sof/eof/data_in : input stream (MSB byte earliest)
//   data_out/data_out_valid    : input delayed by DELAY_WORDS cycles
//   match_vec/match            : sticky per-entry hits for the current frame
//   match_pulse/idx/offset     : first hit of the frame and its byte offset
// PATTERN_BYTES must be at least 2 and DELAY_WORDS at least 1.
module stream_pattern_matcher
    import sniffer_pkg::*;
#(
    parameter int NUM_PATTERNS  = 4,
    parameter int PATTERN_BYTES = 6,
    parameter int DATA_BYTES    = 4,
    parameter int DELAY_WORDS   = 5,
    localparam int IDX_W        = (NUM_PATTERNS > 1) ? clog2(NUM_PATTERNS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic [8*PATTERN_BYTES-1:0] cfg_pattern,
    input  logic                       cfg_enable,
    input  logic                       data_valid,
    input  logic                       sof,
    input  logic                       eof,
    input  logic [8*DATA_BYTES-1:0]    data_in,
    output logic [8*DATA_BYTES-1:0]    data_out,
    output logic                       data_out_valid,
    output logic [NUM_PATTERNS-1:0]    match_vec,
    output logic                       match,
    output logic                       match_pulse,
    output logic [IDX_W-1:0]           match_idx,
    output logic [OFFSET_W-1:0]        match_offset
);

    localparam int HIST_BYTES = PATTERN_BYTES - 1;
    localparam int WIN_BYTES  = HIST_BYTES + DATA_BYTES;
    localparam int BC_W       = BYTE_COUNT_W;

    // Pattern table
    logic [8*PATTERN_BYTES-1:0] r_pattern [NUM_PATTERNS];
    logic [NUM_PATTERNS-1:0]    r_enable;

    // Frame state
    frame_state_t               r_state;
    logic [8*HIST_BYTES-1:0]    r_history;
    logic [BC_W-1:0]            r_byte_count;
    logic [NUM_PATTERNS-1:0]    r_match_vec;
    logic                       r_match_pulse;
    logic [IDX_W-1:0]           r_match_idx;
    logic [OFFSET_W-1:0]        r_match_offset;

    // Delay line
    logic [8*DATA_BYTES-1:0]    r_dly_data  [DELAY_WORDS];
    logic                       r_dly_valid [DELAY_WORDS];

    logic                                     w_flush;
    logic                                     w_scan;
    logic [8*HIST_BYTES-1:0]                  w_hist_base;
    logic [BC_W-1:0]                          w_bc_base;
    logic [NUM_PATTERNS-1:0]                  w_vec_base;
    logic [8*WIN_BYTES-1:0]                   w_window;
    logic [BC_W:0]                            w_bc_sum;
    logic [NUM_PATTERNS-1:0][DATA_BYTES-1:0]  w_hits;
    logic [NUM_PATTERNS-1:0]                  w_hit_flags;
    logic [DATA_BYTES-1:0][OFFSET_W-1:0]      w_align_off;
    logic                                     w_any_hit;
    logic [IDX_W-1:0]                         w_pick_idx;
    logic [OFFSET_W-1:0]                      w_pick_off;

    assign w_flush = rst | clear;
    // Outside a frame only a start-of-frame word is looked at.
    assign w_scan  = data_valid & ~w_flush & (sof | (r_state == IN_FRAME));

    // A sof word starts from empty history, zero count and cleared flags,
    // even when it interrupts a running frame.
    assign w_hist_base = sof ? {(8*HIST_BYTES){1'b0}} : r_history;
    assign w_bc_base   = sof ? {BC_W{1'b0}}           : r_byte_count;
    assign w_vec_base  = sof ? {NUM_PATTERNS{1'b0}}   : r_match_vec;
    assign w_window    = {w_hist_base, data_in};
    assign w_bc_sum    = {1'b0, w_bc_base} + (BC_W+1)'(DATA_BYTES);

    generate
        for (genvar gi = 0; gi < NUM_PATTERNS; gi++) begin : g_entry
            pattern_entry_cmp #(
                .PATTERN_BYTES (PATTERN_BYTES),
                .DATA_BYTES    (DATA_BYTES)
            ) u_cmp (
                .i_window     (w_window),
                .i_pattern    (r_pattern[gi]),
                .i_enable     (r_enable[gi]),
                .i_byte_count (w_bc_base),
                .o_hit        (w_hits[gi])
            );
            assign w_hit_flags[gi] = |w_hits[gi];
        end

        // Start offset of a pattern ending at word byte gi, clamped to 16 bits.
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_offset
            logic [BC_W:0] w_raw;
            assign w_raw = {1'b0, w_bc_base} + (BC_W+1)'(gi + 1) - (BC_W+1)'(PATTERN_BYTES);
            assign w_align_off[gi] = (|w_raw[BC_W:OFFSET_W]) ? {OFFSET_W{1'b1}}
                                                              : w_raw[OFFSET_W-1:0];
        end
    endgenerate

    // Lowest-index hitting entry wins; within it the earliest alignment wins.
    // Iterating downwards lets the lowest index / alignment be written last.
    always_comb begin
        w_any_hit  = 1'b0;
        w_pick_idx = '0;
        w_pick_off = '0;
        for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
            if (w_hit_flags[p]) begin
                w_any_hit  = 1'b1;
                w_pick_idx = IDX_W'(p);
                for (int k = DATA_BYTES - 1; k >= 0; k--) begin
                    if (w_hits[p][k]) begin
                        w_pick_off = w_align_off[k];
                    end
                end
            end
        end
    end

    // Pattern table: only rst wipes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PATTERNS; p++) begin
                r_pattern[p] <= '0;
            end
            r_enable <= '0;
        end else if (cfg_we) begin
            r_pattern[cfg_idx] <= cfg_pattern;
            r_enable[cfg_idx]  <= cfg_enable;
        end
    end

    // Frame FSM, history, byte counter and hit reporting.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state        <= IDLE;
            r_history      <= '0;
            r_byte_count   <= '0;
            r_match_vec    <= '0;
            r_match_pulse  <= 1'b0;
            r_match_idx    <= '0;
            r_match_offset <= '0;
        end else begin
            r_match_pulse <= 1'b0;
            if (w_scan) begin
                r_state      <= eof ? IDLE : IN_FRAME;
                r_history    <= w_window[8*HIST_BYTES-1:0];
                r_byte_count <= w_bc_sum[BC_W] ? {BC_W{1'b1}} : w_bc_sum[BC_W-1:0];
                r_match_vec  <= w_vec_base | w_hit_flags;
                if (~(|w_vec_base) && w_any_hit) begin
                    r_match_pulse  <= 1'b1;
                    r_match_idx    <= w_pick_idx;
                    r_match_offset <= w_pick_off;
                end
            end
        end
    end

    // Fixed-latency passthrough; shifts every cycle regardless of data_valid.
    generate
        for (genvar gi = 0; gi < DELAY_WORDS; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (w_flush) begin
                        r_dly_data[gi]  <= '0;
                        r_dly_valid[gi] <= 1'b0;
                    end else begin
                        r_dly_data[gi]  <= data_in;
                        r_dly_valid[gi] <= data_valid;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (w_flush) begin
                        r_dly_data[gi]  <= '0;
                        r_dly_valid[gi] <= 1'b0;
                    end else begin
                        r_dly_data[gi]  <= r_dly_data[gi-1];
                        r_dly_valid[gi] <= r_dly_valid[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign data_out       = r_dly_data[DELAY_WORDS-1];
    assign data_out_valid = r_dly_valid[DELAY_WORDS-1];
    assign match_vec      = r_match_vec;
    assign match          = |r_match_vec;
    assign match_pulse    = r_match_pulse;
    assign match_idx      = r_match_idx;
    assign match_offset   = r_match_offset;

endmodule

// File: tb/tb_stream_pattern_matcher.sv
// Self-checking bench for stream_pattern_matcher (default parameters).
// A byte-list reference model searches each frame for the table patterns
// and a queue models the passthrough latency.
module tb_stream_pattern_matcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [47:0] cfg_pattern = '0;
    logic        cfg_enable = 1'b0;
    logic        data_valid = 1'b0;
    logic        sof = 1'b0;
    logic        eof = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic [3:0]  match_vec;
    logic        match;
    logic        match_pulse;
    logic [1:0]  match_idx;
    logic [15:0] match_offset;

    stream_pattern_matcher dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_pattern    (cfg_pattern),
        .cfg_enable     (cfg_enable),
        .data_valid     (data_valid),
        .sof            (sof),
        .eof            (eof),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .match_vec      (match_vec),
        .match          (match),
        .match_pulse    (match_pulse),
        .match_idx      (match_idx),
        .match_offset   (match_offset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_step   = 0;

    // Reference model state
    logic [7:0]  m_frame[$];
    logic [47:0] m_pat [4];
    logic        m_en  [4];
    logic        m_in_frame = 1'b0;
    logic [3:0]  m_vec = '0;
    logic        m_pulse = 1'b0;
    logic [1:0]  m_idx = '0;
    logic [15:0] m_off = '0;
    logic [32:0] m_dly[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
        end
    endtask

    task automatic model_scan();
        logic [3:0] hits;
        int         first_off [4];
        int         base;
        logic       ok;
        if (sof) begin
            m_frame.delete();
            m_vec = '0;
        end
        base = m_frame.size();
        for (int b = 0; b < 4; b++) m_frame.push_back(data_in[31-8*b -: 8]);
        hits = '0;
        for (int p = 0; p < 4; p++) begin
            first_off[p] = 0;
            if (m_en[p]) begin
                for (int e = base; e < base + 4; e++) begin
                    if (!hits[p] && e >= 5) begin
                        ok = 1'b1;
                        for (int j = 0; j < 6; j++)
                            if (m_frame[e-5+j] != m_pat[p][47-8*j -: 8]) ok = 1'b0;
                        if (ok) begin
                            hits[p]      = 1'b1;
                            first_off[p] = e - 5;
                        end
                    end
                end
            end
        end
        if (m_vec == 4'b0 && hits != 4'b0) begin
            m_pulse = 1'b1;
            for (int p = 3; p >= 0; p--) begin
                if (hits[p]) begin
                    m_idx = 2'(p);
                    m_off = 16'(first_off[p]);
                end
            end
        end
        m_vec      = m_vec | hits;
        m_in_frame = !eof;
    endtask

    task automatic model_update();
        if (rst || clear) begin
            m_in_frame = 1'b0;
            m_frame.delete();
            m_vec   = '0;
            m_pulse = 1'b0;
            m_idx   = '0;
            m_off   = '0;
            m_dly.delete();
            repeat (5) m_dly.push_back(33'd0);
            if (rst) for (int p = 0; p < 4; p++) begin
                m_pat[p] = '0;
                m_en[p]  = 1'b0;
            end
        end else begin
            m_dly.push_back({data_valid, data_in});
            void'(m_dly.pop_front());
            m_pulse = 1'b0;
            if (data_valid && (sof || m_in_frame)) model_scan();
        end
        if (cfg_we && !rst) begin
            m_pat[cfg_idx] = cfg_pattern;
            m_en[cfg_idx]  = cfg_enable;
        end
    endtask

    // One clock: update model at the edge, compare just after it, then
    // return inputs to idle with random filler data.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        n_step++;
        chk("match_vec", 64'(match_vec), 64'(m_vec));
        chk("match", 64'(match), 64'(|m_vec));
        chk("match_pulse", 64'(match_pulse), 64'(m_pulse));
        chk("match_idx", 64'(match_idx), 64'(m_idx));
        chk("match_offset", 64'(match_offset), 64'(m_off));
        chk("data_out", 64'(data_out), 64'(m_dly[0][31:0]));
        chk("data_out_valid", 64'(data_out_valid), 64'(m_dly[0][32]));
        rst        = 1'b0;
        clear      = 1'b0;
        cfg_we     = 1'b0;
        data_valid = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        data_in    = $urandom;
    endtask

    task automatic word(input logic s, input logic e, input logic [31:0] d);
        data_valid = 1'b1;
        sof        = s;
        eof        = e;
        data_in    = d;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [47:0] pat, input logic en);
        cfg_we      = 1'b1;
        cfg_idx     = idx;
        cfg_pattern = pat;
        cfg_enable  = en;
    endtask

    function automatic logic [7:0] rand_byte();
        return ($urandom_range(0, 1) == 1) ? 8'hAA : 8'h55;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = rand_byte();
        return w;
    endfunction

    function automatic logic [47:0] rand_pat();
        logic [47:0] w;
        for (int b = 0; b < 6; b++) w[8*b +: 8] = rand_byte();
        return w;
    endfunction

    initial begin
        for (int p = 0; p < 4; p++) begin
            m_pat[p] = '0;
            m_en[p]  = 1'b0;
        end
        repeat (5) m_dly.push_back(33'd0);

        // Reset
        rst = 1'b1; step();
        rst = 1'b1; step();
        chk("rst_vec", 64'(match_vec), 64'h0);
        chk("rst_offset", 64'(match_offset), 64'h0);
        chk("rst_dout_valid", 64'(data_out_valid), 64'h0);

        // Aligned MAC
        cfg(2'd0, 48'h001122334455, 1'b1); step();
        word(1'b1, 1'b0, 32'h00112233); step();
        chk("aligned_early", 64'(match_pulse), 64'h0);
        word(1'b0, 1'b1, 32'h44550000); step();
        chk("aligned_pulse", 64'(match_pulse), 64'h1);
        chk("aligned_idx", 64'(match_idx), 64'h0);
        chk("aligned_offset", 64'(match_offset), 64'h0);
        chk("aligned_vec", 64'(match_vec), 64'h1);
        step();
        chk("aligned_pulse_once", 64'(match_pulse), 64'h0);
        chk("aligned_sticky", 64'(match_vec), 64'h1);

        // Misaligned across three words
        word(1'b1, 1'b0, 32'hAABBCC00); step();
        word(1'b0, 1'b0, 32'h11223344); step();
        chk("mis_early", 64'(match_pulse), 64'h0);
        word(1'b0, 1'b1, 32'h55FFFFFF); step();
        chk("mis_pulse", 64'(match_pulse), 64'h1);
        chk("mis_offset", 64'(match_offset), 64'h3);
        chk("mis_vec", 64'(match_vec), 64'h1);

        // Frame boundary: the pattern straddles two frames
        word(1'b1, 1'b0, 32'h99999999); step();
        chk("bound_sof_clr", 64'(match_vec), 64'h0);
        word(1'b0, 1'b1, 32'h00112233); step();
        word(1'b1, 1'b1, 32'h44550000); step();
        chk("bound_match", 64'(match), 64'h0);
        chk("bound_vec", 64'(match_vec), 64'h0);

        // Priority and enable
        cfg(2'd1, 48'hDEADBEEF0102, 1'b0); step();
        cfg(2'd2, 48'hDEADBEEF0102, 1'b1); step();
        word(1'b1, 1'b0, 32'h12DEADBE); step();
        word(1'b0, 1'b0, 32'hEF010234); step();
        chk("prio_pulse", 64'(match_pulse), 64'h1);
        chk("prio_idx", 64'(match_idx), 64'h2);
        chk("prio_offset", 64'(match_offset), 64'h1);
        chk("prio_vec", 64'(match_vec), 64'h4);
        cfg(2'd1, 48'hDEADBEEF0102, 1'b1); step();
        word(1'b0, 1'b0, 32'hDEADBEEF); step();
        word(1'b0, 1'b0, 32'h0102AAAA); step();
        chk("reen_vec", 64'(match_vec), 64'h6);
        chk("reen_no_pulse", 64'(match_pulse), 64'h0);
        chk("reen_idx_held", 64'(match_idx), 64'h2);
        word(1'b0, 1'b1, 32'h00000000); step();

        // Random stream against the model
        for (int p = 0; p < 4; p++) begin
            cfg(2'(p), rand_pat(), ($urandom_range(0, 3) != 0)); step();
        end
        for (int i = 0; i < 400; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            sof        = ($urandom_range(0, 5) == 0);
            eof        = ($urandom_range(0, 4) == 0);
            data_in    = rand_word();
            if ($urandom_range(0, 39) == 0) begin
                cfg_we      = 1'b1;
                cfg_idx     = 2'($urandom_range(0, 3));
                cfg_pattern = rand_pat();
                cfg_enable  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 99) == 0) clear = 1'b1;
            step();
        end
        word(1'b0, 1'b1, 32'h0); step();

        // rst mid-frame after a hit
        cfg(2'd0, 48'h001122334455, 1'b1); step();
        word(1'b1, 1'b0, 32'hFF001122); step();
        word(1'b0, 1'b0, 32'h33445500); step();
        chk("rmf_pulse", 64'(match_pulse), 64'h1);
        chk("rmf_offset", 64'(match_offset), 64'h1);
        rst = 1'b1; step();
        chk("rmf_rst_vec", 64'(match_vec), 64'h0);
        chk("rmf_rst_offset", 64'(match_offset), 64'h0);
        chk("rmf_rst_dvalid", 64'(data_out_valid), 64'h0);
        chk("rmf_rst_dout", 64'(data_out), 64'h0);
        word(1'b1, 1'b0, 32'hFF001122); step();
        word(1'b0, 1'b1, 32'h33445500); step();
        chk("rmf_table_wiped", 64'(match), 64'h0);

        // clear mid-frame keeps the table
        cfg(2'd0, 48'h001122334455, 1'b1); step();
        word(1'b1, 1'b0, 32'hFF001122); step();
        word(1'b0, 1'b0, 32'h33445500); step();
        chk("clr_hit", 64'(match_vec), 64'h1);
        clear = 1'b1; step();
        chk("clr_vec", 64'(match_vec), 64'h0);
        chk("clr_offset", 64'(match_offset), 64'h0);
        word(1'b1, 1'b0, 32'hFF001122); step();
        word(1'b0, 1'b1, 32'h33445500); step();
        chk("clr_rehit_pulse", 64'(match_pulse), 64'h1);
        chk("clr_rehit_offset", 64'(match_offset), 64'h1);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
